// File: rtl/rv32_regfile.sv
// Parametrised RV32I/RV32E integer register file with latched read addresses, optional
// write-to-read bypass and a post-reset clear sequencer for the non-resettable array.
module rv32_regfile #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_in,
  input  logic                  writeback_flush_in,
  input  logic [NREAD*AW-1:0]   rs_in,
  input  logic [AW-1:0]         rd_in,
  input  logic                  rd_write_in,
  input  logic [XLEN-1:0]       rd_value_in,
  output logic [NREAD*XLEN-1:0] rs_value_out,
  output logic                  clearing_out
);

  typedef enum logic {StClear, StReady} state_e;

  state_e              state_q;
  logic [AW-1:0]       cnt_q;
  logic [NREAD*AW-1:0] rs_q;
  logic [XLEN-1:0]     regs_q [NREGS];
  logic                clearing;
  logic                wr_en;

  assign clearing     = (state_q == StClear);
  assign clearing_out = clearing;
  assign wr_en        = !clearing && rd_write_in && !writeback_flush_in && (rd_in != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StClear;
      cnt_q   <= AW'(1);
      rs_q    <= '0;
    end else begin
      if (clearing) begin
        cnt_q <= cnt_q + AW'(1);
        if (cnt_q == AW'(NREGS - 1)) begin
          state_q <= StReady;
        end
      end
      if (!stall_in) begin
        rs_q <= rs_in;
      end
    end
  end

  // The array has no reset; entry 0 is never written and is masked on read instead.
  always_ff @(posedge clk) begin
    if (clearing) begin
      regs_q[cnt_q] <= '0;
    end else if (wr_en) begin
      regs_q[rd_in] <= rd_value_in;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_read
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;

    assign addr = rs_q[k*AW +: AW];

    always_comb begin
      data = '0;
      if (clearing || (addr == '0)) begin
        data = '0;
      end else if ((BYPASS != 0) && wr_en && (rd_in == addr)) begin
        data = rd_value_in;
      end else begin
        data = regs_q[addr];
      end
    end

    assign rs_value_out[k*XLEN +: XLEN] = data;
  end

endmodule

// File: doc/rv32_regfile.md
Name: rv32_regfile

Overview:
- Parametrised successor to the RV32 integer register file.
- Width, register count (RV32I/RV32E) and read-port count are configurable.
- Read addresses are latched in decode, unless stalled; read data is consumed in the next stage.
- Adds optional write-to-read bypass and a hardware clear sequencer that zeroes the array after reset, since the RAM itself cannot be asynchronously reset.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (32 for RV32I, 16 for RV32E); power of two, at least 2.
- NREAD, 2, number of independent read ports.
- BYPASS, 1, 1 = a same-cycle write to a latched read address is forwarded to that read output; 0 = no forwarding.
- AW, $clog2(NREGS), derived register-address width; not overridable.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- stall_in  in  1  holds the latched read addresses
- writeback_flush_in  in  1  suppresses the current write
- rs_in  in  NREAD*AW  read addresses; port k = bits [k*AW +: AW]
- rd_in  in  AW  write address
- rd_write_in  in  1  write enable
- rd_value_in  in  XLEN  write data
- rs_value_out  out  NREAD*XLEN  read data; port k = bits [k*XLEN +: XLEN]
- clearing_out  out  1  high while the clear sequencer runs; pipeline must stall

Behaviour:
- Registers, all asynchronously reset by reset: rs_q[k] (AW each, reset 0), clear counter cnt (AW, reset 1), state (reset CLEAR).
- Array contents are not reset.
- While reset is asserted: clearing_out=1 and all rs_value_out=0.

State machine:
- CLEAR:
  - Each clk edge writes 0 to regs[cnt] and increments cnt.
  - When cnt == NREGS-1, that entry is written and state goes to READY.
  - Clearing takes NREGS-1 edges after reset deasserts, i.e. 31 for NREGS=32.
- READY: terminal state until the next reset.
- Reset asserted mid-CLEAR or in READY: returns to CLEAR with cnt=1; the whole sequence restarts.

clearing_out and outputs during CLEAR:
- clearing_out = (state==CLEAR); registered state, no combinational path from inputs.
- In CLEAR, user writes are ignored and every rs_value_out is forced to 0.
- rs_q still latches rs_in per the stall rule.

Read path:
- Each edge with !stall_in: rs_q[k] <= rs_in[k].
- stall_in=1 holds rs_q. stall_in has no effect on writes.
- rs_value_out[k], combinational from rs_q[k]:
  - 0 if rs_q[k]==0 or state==CLEAR;
  - else rd_value_in if BYPASS && wr_en && rd_in==rs_q[k];
  - else regs[rs_q[k]].

Write path:
- wr_en = (state==READY) && rd_write_in && !writeback_flush_in && rd_in!=0.
- When wr_en, regs[rd_in] <= rd_value_in at the edge.
- Register 0 is never written; it always reads 0, including via bypass.

Boundary conditions:
- Several read ports may hold the same address; each resolves identically.
- Write and read of the same address in one cycle: with BYPASS=1 the output shows the new value that cycle; with BYPASS=0 it shows the old value, and the new value from the next cycle.
- Flush together with a write: no array update and no bypass.
- rd_in values outside 0..NREGS-1 cannot occur, since AW bits exactly cover NREGS.
- Latency: read data is valid the cycle after the address is latched. Write-to-array is one edge.

Test Plan:
- Reset, then release with NREGS=32: clearing_out stays 1 for exactly 31 edges, then 0. Reading every address afterwards returns 0 even if the array was preloaded with 0xDEADBEEF before reset.
- Reset pulsed again at cnt=10: clearing_out stays high; clearing restarts and completes 31 edges after the second release.
- Write x5=0x12345678, then read rs_in={5,5}: both ports show 0x12345678 one cycle later. Write x0=0xFFFFFFFF: x0 still reads 0.
- Latched rs_q[0]=7, writing x7=0xA5A5A5A5 this cycle: BYPASS=1 gives 0xA5A5A5A5 that same cycle; BYPASS=0 gives the old value, then 0xA5A5A5A5 next cycle. Same write with writeback_flush_in=1: x7 unchanged and nothing forwarded.
- stall_in=1 with rs_in changed from 3 to 9: output keeps x3's value. Releasing the stall switches the output to x9's value after one edge.
- NREGS=16, NREAD=3, XLEN=64: clear takes 15 edges. Three ports read x1, x2, x15 after 64-bit writes 0x1_0000_0001, 0x2, and 0xFFFF_FFFF_FFFF_FFFF, and return those values.
